// File: rtl/frame_xor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_xor_pkg                                                              |
// | Shared types, mode encodings and key-word selection for frame_xor_cipher.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package frame_xor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_REPEAT = 1'b0;
    localparam logic MODE_CTR    = 1'b1;

    // Widest flattened key the selector accepts; callers zero-extend into it.
    localparam int KEY_W_MAX = 1024;

    // Returns the key shifted so that word idx sits in the low bits;
    // the caller truncates to its word width.
    function automatic logic [KEY_W_MAX-1:0] key_word_sel(
        input logic [KEY_W_MAX-1:0] key_flat,
        input logic [31:0]          idx,
        input logic [31:0]          word_w
    );
        return key_flat >> (idx * word_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_xor_cipher_keystream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keystream_gen                                                              |
// | Combinational keystream word: key word[idx], optionally mixed with n.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module keystream_gen
    import frame_xor_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [KEY_BYTES*DATA_W-1:0] key,
    input  logic [IDX_W-1:0]            idx,
    input  logic [DATA_W-1:0]           n_lo,
    input  logic                        mode,
    output logic [DATA_W-1:0]           ks
);

    logic [DATA_W-1:0] w_word;

    always_comb begin
        w_word = DATA_W'(key_word_sel(KEY_W_MAX'(key), 32'(idx), 32'(DATA_W)));
        ks     = (mode == MODE_CTR) ? (w_word ^ n_lo) : w_word;
    end

endmodule
`default_nettype wire

// File: rtl/frame_xor_cipher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_xor_cipher                                                           |
// | Sweeps one frame from a source BRAM, XOR-ciphers it, writes a dest BRAM.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_xor_cipher
    import frame_xor_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 15,
    parameter int FRAME_LEN = 19200,
    parameter int KEY_BYTES = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        enable,
    input  logic                        mode,
    input  logic [KEY_BYTES*DATA_W-1:0] key,
    output logic [ADDR_W-1:0]           read_addr,
    input  logic [DATA_W-1:0]           encrypted_data,
    output logic [ADDR_W-1:0]           write_addr,
    output logic [DATA_W-1:0]           decrypted_data,
    output logic                        write_en,
    output logic                        busy,
    output logic                        done
);

    localparam int                IDX_W      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] c_LAST_N   = ADDR_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(KEY_BYTES - 1);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [ADDR_W-1:0]             r_n;
    logic [IDX_W-1:0]              r_idx;
    logic [KEY_BYTES*DATA_W-1:0]   r_key;
    logic                          r_mode;

    // Token pipe: stage RD_LAT lines up with the returning read data.
    logic [RD_LAT:0]               r_pipe_vld;
    logic [ADDR_W-1:0]             r_pipe_n   [RD_LAT+1];
    logic [IDX_W-1:0]              r_pipe_idx [RD_LAT+1];

    logic                          w_issue;
    logic                          w_pipe_busy;
    logic [DATA_W-1:0]             w_ks;

    assign w_issue     = (r_state == RUN) && enable;
    assign w_pipe_busy = |r_pipe_vld;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (w_issue && (r_n == c_LAST_N)) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!w_pipe_busy) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    keystream_gen #(
        .DATA_W    (DATA_W),
        .KEY_BYTES (KEY_BYTES),
        .IDX_W     (IDX_W)
    ) u_keystream_gen (
        .key  (r_key),
        .idx  (r_pipe_idx[RD_LAT]),
        .n_lo (DATA_W'(r_pipe_n[RD_LAT])),
        .mode (r_mode),
        .ks   (w_ks)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_n            <= '0;
            r_idx          <= '0;
            r_key          <= '0;
            r_mode         <= MODE_REPEAT;
            read_addr      <= '0;
            write_addr     <= '0;
            decrypted_data <= '0;
            write_en       <= 1'b0;
            r_pipe_vld     <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                r_pipe_n[i]   <= '0;
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == IDLE) && start) begin
                r_key  <= key;
                r_mode <= mode;
                r_n    <= '0;
                r_idx  <= '0;
            end

            if (w_issue) begin
                read_addr <= r_n;
                r_n       <= (r_n == c_LAST_N) ? r_n : r_n + ADDR_W'(1);
                r_idx     <= (r_idx == c_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end

            r_pipe_vld[0] <= w_issue;
            r_pipe_n[0]   <= r_n;
            r_pipe_idx[0] <= r_idx;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_n[i]   <= r_pipe_n[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end

            write_en <= r_pipe_vld[RD_LAT];
            if (r_pipe_vld[RD_LAT]) begin
                decrypted_data <= encrypted_data ^ w_ks;
                write_addr     <= r_pipe_n[RD_LAT];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_xor_cipher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_xor_cipher                                                        |
// | Directed vectors on a 4-word-key and a 1-word-key instance, FRAME_LEN=8.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_frame_xor_cipher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        enable = 1'b1;
    logic        mode = 1'b0;
    logic [31:0] key = '0;

    logic [14:0] ra4, wa4, ra1, wa1;
    logic [7:0]  enc4, enc1, wd4, wd1;
    logic        we4, we1, busy4, busy1, done4, done1;

    logic [7:0]  mem [8];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_s     = 0;

    logic [22:0] q4[$];
    logic [22:0] q1[$];
    int done_cnt4, done_cnt1, done_cyc4, first4;

    typedef struct {
        logic        mode;
        logic [31:0] key;
        logic        fill_n;
        logic [63:0] exp4;
        logic [63:0] exp1;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        enc4 <= mem[ra4[2:0]];
        enc1 <= mem[ra1[2:0]];
    end

    always @(negedge clk) begin
        if (we4) begin
            q4.push_back({wa4, wd4});
            if (first4 < 0) first4 = cyc;
        end
        if (we1) q1.push_back({wa1, wd1});
        if (done4) begin
            done_cnt4++;
            done_cyc4 = cyc;
        end
        if (done1) done_cnt1++;
    end

    frame_xor_cipher #(
        .DATA_W(8), .ADDR_W(15), .FRAME_LEN(8), .KEY_BYTES(4), .RD_LAT(1)
    ) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .mode(mode),
        .key(key), .read_addr(ra4), .encrypted_data(enc4), .write_addr(wa4),
        .decrypted_data(wd4), .write_en(we4), .busy(busy4), .done(done4)
    );

    frame_xor_cipher #(
        .DATA_W(8), .ADDR_W(15), .FRAME_LEN(8), .KEY_BYTES(1), .RD_LAT(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .mode(mode),
        .key(key[7:0]), .read_addr(ra1), .encrypted_data(enc1), .write_addr(wa1),
        .decrypted_data(wd1), .write_en(we1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input vec_t v);
        for (int k = 0; k < 8; k++) mem[k] = v.fill_n ? 8'(k) : 8'h00;
        key  = v.key;
        mode = v.mode;
        q4.delete();
        q1.delete();
        done_cnt4 = 0;
        done_cnt1 = 0;
        done_cyc4 = -1;
        first4    = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_s = cyc;
    endtask

    // stall: enable low for 3 cycles once read_addr shows 3; restart: start pulse while busy
    task automatic run_frame(input string tag, input vec_t v, input bit stall, input bit restart);
        logic [63:0] e4, e1;
        int rel;
        int exp_lat;
        start_frame(v);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            rel = cyc - t_s;
            if (stall) begin
                if (rel == 4) enable = 1'b0;
                if (rel >= 5 && rel <= 7)
                    check($sformatf("%s stall read_addr rel%0d", tag, rel), 64'(ra4), 64'd3);
                if (rel == 7) enable = 1'b1;
            end
            if (restart) begin
                if (rel == 5) start = 1'b1;
                if (rel == 6) start = 1'b0;
            end
            if (done_cnt4 > 0) break;
        end
        repeat (3) @(negedge clk);
        #1;
        exp_lat = stall ? 14 : 11;
        e4 = v.exp4;
        e1 = v.exp1;
        check({tag, " wr count k4"}, 64'(q4.size()), 64'd8);
        check({tag, " wr count k1"}, 64'(q1.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s k4 write %0d", tag, k), 64'(q4[k]), 64'({15'(k), e4[k*8 +: 8]}));
            check($sformatf("%s k1 write %0d", tag, k), 64'(q1[k]), 64'({15'(k), e1[k*8 +: 8]}));
        end
        check({tag, " done pulses k4"}, 64'(done_cnt4), 64'd1);
        check({tag, " done pulses k1"}, 64'(done_cnt1), 64'd1);
        check({tag, " done latency"}, 64'(done_cyc4 - t_s), 64'(exp_lat));
        check({tag, " first write latency"}, 64'(first4 - t_s), 64'd3);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h44332211, 1'b0, 64'h44332211_44332211, 64'h11111111_11111111};
        vecs[1] = '{1'b1, 32'h44332211, 1'b0, 64'h43352715_47312311, 64'h16171415_12131011};
        vecs[2] = '{1'b0, 32'h44332211, 1'b1, 64'h43352715_47312311, 64'h16171415_12131011};
        vecs[3] = '{1'b1, 32'h44332211, 1'b1, 64'h44332211_44332211, 64'h11111111_11111111};
        vecs[4] = '{1'b0, 32'hA5C300B3, 1'b1, 64'hA2C505B7_A6C101B3, 64'hB4B5B6B7_B0B1B2B3};
        for (int k = 0; k < 8; k++) mem[k] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset read_addr",  64'(ra4), 64'd0);
        check("reset write_addr", 64'(wa4), 64'd0);
        check("reset data",       64'(wd4), 64'd0);
        check("reset ctl",        64'({we4, busy4, done4, we1, busy1, done1}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);

        run_frame("stall", vecs[4], 1'b1, 1'b0);
        run_frame("restart", vecs[1], 1'b0, 1'b1);
        run_frame("after_restart", vecs[0], 1'b0, 1'b0);

        // reset while RUN has read_addr=4 on the bus
        start_frame(vecs[2]);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midreset write_en", 64'({we4, we1}), 64'd0);
        check("midreset busy",     64'({busy4, busy1}), 64'd0);
        check("midreset read_addr", 64'(ra4), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midreset no done", 64'(done_cnt4 + done_cnt1), 64'd0);

        run_frame("post_reset", vecs[4], 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_xor_cipher.md
Name: frame_xor_cipher

Overview:
- Parametrised successor to the single-byte streaming XOR decrypter.
- Sweeps one frame buffer of FRAME_LEN words, reading from a source BRAM and writing XOR-ciphered words to a destination BRAM.
- Adds a runtime multi-byte key, a counter-mixed keystream mode, a start/busy/done handshake, stall support and a clean end-of-frame drain.
- Sits between the encrypted image store and the VGA frame buffer. Because XOR is symmetric, the same block also encrypts.

Parameters:
DATA_W, 8, pixel/word width in bits
ADDR_W, 15, address width of both memories
FRAME_LEN, 19200, words per frame (1..2^ADDR_W)
KEY_BYTES, 4, number of DATA_W-wide key words in the rolling key
RD_LAT, 1, source memory read latency in cycles (fixed)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
enable  in  1  when low, no new reads issue; in-flight words still complete
mode  in  1  0 = repeating key; 1 = key word XOR address low bits (sampled at start)
key  in  KEY_BYTES*DATA_W  key; word i = key[i*DATA_W +: DATA_W] (sampled at start)
read_addr  out  ADDR_W  source memory address
encrypted_data  in  DATA_W  source memory read data, valid RD_LAT cycles after read_addr
write_addr  out  ADDR_W  destination address
decrypted_data  out  DATA_W  destination write data
write_en  out  1  destination write strobe
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset values: read_addr=0, write_addr=0, decrypted_data=0, write_en=0, busy=0, done=0, FSM=IDLE, counters=0.
- rst has priority over all other inputs.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches key and mode, clears the read counter n and the key index, sets busy, and moves to RUN.
  - start in any other state is ignored.
- RUN, on each cycle with enable=1:
  - read_addr<=n; a valid token tagged (n, key index) enters the RD_LAT+1-deep shift pipe.
  - n increments; key index increments mod KEY_BYTES.
  - When n==FRAME_LEN-1 is issued, go to DRAIN.
- RUN, on each cycle with enable=0: read_addr holds and a bubble enters the pipe.
- Write stage: when the token exits after RD_LAT cycles:
  - decrypted_data <= encrypted_data ^ ks
  - write_addr <= tag n
  - write_en <= 1
  - Otherwise write_en <= 0.
- Latency: write_en for address n asserts exactly RD_LAT+1 cycles after read_addr=n is driven.
- Keystream:
  - mode 0: ks = key word[idx].
  - mode 1: ks = key word[idx] ^ n[DATA_W-1:0]. If ADDR_W < DATA_W, n is zero-extended.
- DRAIN: waits for the pipe to empty; enable has no effect here. Then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- Boundaries:
  - FRAME_LEN=1 is legal.
  - n never exceeds FRAME_LEN-1, so no wrap past the frame.
  - The key index wraps at KEY_BYTES-1 -> 0. KEY_BYTES=1 reproduces the legacy single-key behaviour.
- Simultaneous start and rst: reset wins.
- Reset mid-frame: write_en is 0 from the next edge, the pipe is flushed, no done pulse is issued, and the partially written frame is left as is.
- The key and mode ports may change while busy without effect.

Decomposition:
- Package frame_xor_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - the MODE_REPEAT and MODE_CTR constants
  - the key-word select function
- One sub-module, keystream_gen: combinational selection from latched key, idx, n and mode to ks. It is instantiated once in the write stage.
- Top level holds the FSM, counters, token pipe and output registers.

Test Plan:
1. FRAME_LEN=8, KEY_BYTES=1, key=0xB3, mode 0, memory[n]=n:
   - write sequence (addr, data) = (0,0xB3), (1,0xB2) … (7,0xB4)
   - one done pulse, 8 write_en cycles total
2. KEY_BYTES=4, key=0x44332211, mode 0, memory all 0x00:
   - writes 0x11, 0x22, 0x33, 0x44, 0x11…
   - confirms the key index wraps at 4
3. Same key, mode 1, memory all 0x00:
   - address 5 writes 0x22^0x05=0x27
   - address 4 writes 0x11^0x04=0x15
4. enable held low for 3 cycles mid-frame at n=3:
   - read_addr holds 3
   - write_en for addresses 0..2 still completes
   - no duplicate or skipped addresses
   - done arrives 3 cycles later than in the unstalled run
5. start pulsed again while busy:
   - ignored; frame completes once with a single done pulse
   - after that done, a new start runs a second full frame
6. rst asserted during RUN at n=4:
   - next cycle: write_en=0, busy=0, read_addr=0
   - no done pulse
   - a subsequent start produces a full correct frame from address 0
